// File: rtl/eq_ctrl_pkg.sv
// Shared defaults and types for the equalizer tap sequencer and its coefficient bank.
package eq_ctrl_pkg;

    localparam int NTAPS_DEF   = 4;
    localparam int TAP_W_DEF   = 16;
    localparam int TAP_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        DRAIN   = 2'd2,
        PENDING = 2'd3
    } eq_seq_state_t;

    typedef logic [TAP_W_DEF-1:0] coef_t;

endpackage

// File: rtl/eq_tap_sequencer_bank.sv
// Double-buffered coefficient register file: shadow is written tap by tap,
// active is replaced as a whole on swap and read combinationally.
module eq_coef_bank #(
    parameter int NTAPS = 4,
    parameter int TAP_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_idx,
    input  logic [TAP_W-1:0] wr_data,
    input  logic             swap,
    input  logic [7:0]       rd_idx,
    output logic [TAP_W-1:0] rd_data
);

    logic [TAP_W-1:0] shadow [NTAPS];
    logic [TAP_W-1:0] active [NTAPS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTAPS; i++) begin
                if (wr_en && (wr_idx == 8'(i))) shadow[i] <= wr_data;
                if (swap)                       active[i] <= shadow[i];
            end
        end
    end

    // Indices at or beyond NTAPS read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (rd_idx == 8'(i)) rd_data = active[i];
        end
    end

endmodule

// File: rtl/eq_tap_sequencer.sv
// Walks the tap generator on every eqVal change, fills the shadow bank and
// swaps it into the FIR only on a sample boundary.
//
// state   | meaning
// IDLE    | active bank matches loaded_eq, watching eqVal
// ISSUE   | driving tapnum 0..NTAPS-1, one per cycle
// DRAIN   | waiting TAP_LAT cycles for the last captures
// PENDING | shadow complete, waiting for sample_strobe to swap
module eq_tap_sequencer
    import eq_ctrl_pkg::*;
#(
    parameter int NTAPS   = NTAPS_DEF,
    parameter int TAP_W   = TAP_W_DEF,
    parameter int TAP_LAT = TAP_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       eqVal,
    output logic [7:0]       tapnum,
    input  logic [TAP_W-1:0] desiredTap,
    input  logic             sample_strobe,
    input  logic [7:0]       coef_rd_idx,
    output logic [TAP_W-1:0] coef_rd_data,
    output logic             busy,
    output logic             cfg_swapped,
    output logic [7:0]       active_eq
);

    eq_seq_state_t state, state_nx;
    logic [7:0]    k, k_nx;
    logic [1:0]    drain_cnt, drain_cnt_nx;
    logic [7:0]    req_eq, req_eq_nx;
    logic [7:0]    loaded_eq, loaded_eq_nx;
    logic          force_load, force_load_nx;
    logic [7:0]    active_eq_nx;
    logic          cfg_swapped_nx;
    logic          abort, issue, flush, swap;
    logic          cap_vld, wr_en;
    logic [7:0]    cap_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            k           <= '0;
            drain_cnt   <= '0;
            req_eq      <= '0;
            loaded_eq   <= '0;
            force_load  <= 1'b1;
            active_eq   <= '0;
            cfg_swapped <= 1'b0;
        end else begin
            state       <= state_nx;
            k           <= k_nx;
            drain_cnt   <= drain_cnt_nx;
            req_eq      <= req_eq_nx;
            loaded_eq   <= loaded_eq_nx;
            force_load  <= force_load_nx;
            active_eq   <= active_eq_nx;
            cfg_swapped <= cfg_swapped_nx;
        end
    end

    // Returning to loaded_eq while PENDING is not an abort: the swap completes
    // and IDLE then reloads, which lands on the same bank contents.
    assign abort = ((state == ISSUE || state == DRAIN) && (eqVal != req_eq)) ||
                   ((state == PENDING) && (eqVal != req_eq) && (eqVal != loaded_eq));

    always_comb begin
        state_nx       = state;
        k_nx           = k;
        drain_cnt_nx   = drain_cnt;
        req_eq_nx      = req_eq;
        loaded_eq_nx   = loaded_eq;
        force_load_nx  = force_load;
        active_eq_nx   = active_eq;
        cfg_swapped_nx = 1'b0;
        issue          = 1'b0;
        flush          = 1'b0;
        swap           = 1'b0;
        tapnum         = '0;
        busy           = (state != IDLE);

        if (abort) begin
            flush     = 1'b1;
            req_eq_nx = eqVal;
            k_nx      = '0;
            state_nx  = ISSUE;
            if (state == ISSUE) tapnum = k;
        end else begin
            case (state)
                IDLE: begin
                    if (force_load || (eqVal != loaded_eq)) begin
                        req_eq_nx     = eqVal;
                        force_load_nx = 1'b0;
                        k_nx          = '0;
                        state_nx      = ISSUE;
                    end
                end
                ISSUE: begin
                    tapnum = k;
                    issue  = 1'b1;
                    if (k == 8'(NTAPS - 1)) begin
                        k_nx         = '0;
                        drain_cnt_nx = 2'(TAP_LAT - 1);
                        state_nx     = (TAP_LAT > 0) ? DRAIN : PENDING;
                    end else begin
                        k_nx = k + 8'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd0) state_nx = PENDING;
                    else                   drain_cnt_nx = drain_cnt - 2'd1;
                end
                PENDING: begin
                    if (sample_strobe) begin
                        swap           = 1'b1;
                        cfg_swapped_nx = 1'b1;
                        active_eq_nx   = req_eq;
                        loaded_eq_nx   = req_eq;
                        state_nx       = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    generate
        if (TAP_LAT == 0) begin : g_nolat
            assign cap_vld = issue;
            assign cap_idx = k;
        end else begin : g_lat
            logic       vld_dl [TAP_LAT];
            logic [7:0] idx_dl [TAP_LAT];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < TAP_LAT; i++) begin
                        vld_dl[i] <= 1'b0;
                        idx_dl[i] <= '0;
                    end
                end else if (flush) begin
                    for (int i = 0; i < TAP_LAT; i++) vld_dl[i] <= 1'b0;
                end else begin
                    vld_dl[0] <= issue;
                    idx_dl[0] <= k;
                    for (int i = 1; i < TAP_LAT; i++) begin
                        vld_dl[i] <= vld_dl[i-1];
                        idx_dl[i] <= idx_dl[i-1];
                    end
                end
            end

            assign cap_vld = vld_dl[TAP_LAT-1];
            assign cap_idx = idx_dl[TAP_LAT-1];
        end
    endgenerate

    assign wr_en = cap_vld && !flush;

    eq_coef_bank #(
        .NTAPS (NTAPS),
        .TAP_W (TAP_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (cap_idx),
        .wr_data (desiredTap),
        .swap    (swap),
        .rd_idx  (coef_rd_idx),
        .rd_data (coef_rd_data)
    );

endmodule

// File: doc/eq_tap_sequencer.md
Name: eq_tap_sequencer

Overview:
Controller that configures the equalizer FIR coefficients from the tap generator (new_all_taps).
- On a change of eqVal it walks tapnum 0..NTAPS-1, captures each desiredTap into a shadow coefficient bank, then swaps shadow to active only at a filter sample boundary, so the filter never mixes old and new taps within one output sample.
- Sits between the band-gain input logic and the FIR datapath.

Parameters:
NTAPS, 4, number of filter taps sequenced (1..255)
TAP_W, 16, coefficient width (matches desiredTap)
TAP_LAT, 1, cycles from tapnum driven to desiredTap valid (0..3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
eqVal  in  8  requested band-gain setting
tapnum  out  8  tap index to tap generator
desiredTap  in  TAP_W  coefficient from tap generator
sample_strobe  in  1  one-cycle pulse, FIR sample boundary
coef_rd_idx  in  8  FIR read index into active bank
coef_rd_data  out  TAP_W  active coefficient, combinational read
busy  out  1  load in progress or swap pending
cfg_swapped  out  1  one-cycle pulse when new bank becomes active
active_eq  out  8  eqVal value the active bank was built from

Behaviour:
- Reset (reset=0, async): state=IDLE; tapnum=0; busy=0; cfg_swapped=0; active_eq=0; both banks all-zero; loaded_eq=0; force_load=1.
- States: IDLE, ISSUE, DRAIN, PENDING.
- IDLE: if force_load or eqVal!=loaded_eq, latch req_eq=eqVal, clear force_load, go to ISSUE next cycle. busy=0 only in IDLE.
- ISSUE: tapnum=k for k=0..NTAPS-1, one per cycle (pipelined). After k=NTAPS-1, go to DRAIN if TAP_LAT>0, else PENDING.
- Capture: desiredTap for tapnum driven in cycle c is written to shadow[k] at the end of cycle c+TAP_LAT, via a TAP_LAT-deep valid/index delay line.
- DRAIN: TAP_LAT cycles, completing outstanding captures, then PENDING.
- Load latency: NTAPS+TAP_LAT cycles from ISSUE entry to PENDING.
- PENDING: wait for sample_strobe. On strobe: active<=shadow, active_eq<=req_eq, loaded_eq<=req_eq, cfg_swapped=1 for that cycle, go to IDLE.
- A strobe in the same cycle PENDING is entered does not swap. A swap requires being in PENDING at the strobe.
- sample_strobe outside PENDING is ignored.
- tapnum=0 outside ISSUE.
- eqVal change during ISSUE, DRAIN or PENDING (eqVal!=req_eq): abort, flush the capture delay line, latch new req_eq, restart ISSUE at k=0 next cycle. The active bank is untouched.
- eqVal toggling back to loaded_eq while PENDING still completes the pending swap (idempotent).
- coef_rd_data=active[coef_rd_idx]; 0 when coef_rd_idx>=NTAPS.
- Reads are never stalled. The active bank changes only on the swap edge.
- Reset asserted mid-load: immediate return to reset values. First load after release uses the current eqVal, since force_load guarantees it even when eqVal=0.
- No arithmetic on coefficients; stored bit-exact.

Decomposition:
- Package eq_ctrl_pkg: NTAPS, TAP_W, TAP_LAT defaults; state enum type eq_seq_state_t; coefficient typedef coef_t (logic [TAP_W-1:0]).
- Sub-module eq_coef_bank:
  - double-buffered register file (shadow write port, swap input, combinational active read port, async active-low clear);
  - FSM, delay line and change detection remain in eq_tap_sequencer.

Test Plan:
- Tap generator model: desiredTap = {8'h00, eqVal[3:0]+tapnum}, TAP_LAT=1.
- Reset release with eqVal=8'hF4: tapnum walks 0,1,2,3 over 4 cycles, PENDING after 5 cycles. Strobe gives cfg_swapped pulse, active coefficients 0..3 = 0004,0005,0006,0007, active_eq=F4, busy=0.
- Swap hold: load for eqVal=8'h02 with no strobe for 20 cycles. coef_rd_data stays 0004..0007 and busy=1. First strobe makes coefficients 0002,0003,0004,0005.
- Mid-load change: eqVal F4->01 during ISSUE at k=2. tapnum restarts at 0 next cycle. After strobe, coefficients are 0001..0004, with no F4-derived values present.
- Same-cycle strobe: strobe asserted in the cycle PENDING is entered causes no swap. The next strobe swaps.
- Out-of-range read: coef_rd_idx=4 and 8'hFF both return 0000.
- Async reset mid-DRAIN: outputs go to reset values without a clock. After release, a load of the current eqVal completes normally.
